stage_id_redirect_ctrl: RTL
===========================

# stage_id_redirect_ctrl

Control-flow redirect controller for the instruction-decode stage. It decodes branch, JAL and JALR in ID and waits for operand readiness, stalling ID until operands are ready. It resolves the branch condition, selects the target from the ID address-calculation outputs (or computes the JAL target itself), and delivers a registered redirect to fetch over a valid/ready handshake. It also kills wrong-path instructions in IF/ID until fetch accepts the redirect.

## Interface
Parameters:
- ADDR_WIDTH, 64, PC/address width
- INST_WIDTH, 32, instruction width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a valid instruction
- inst  input  INST_WIDTH  ID instruction; held stable while id_stall=1
- pc  input  ADDR_WIDTH  PC of ID instruction
- bra_addr  input  ADDR_WIDTH  branch target from ID address calc
- jalr_addr  input  ADDR_WIDTH  JALR target (bit0 already cleared)
- opnd_ready  input  1  rs1/rs2 values and compare flags valid this cycle
- cmp_eq, cmp_lt, cmp_ltu  input  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2
- ex_flush  input  1  later-stage flush (trap/mispredict); highest priority
- redirect_ready  input  1  fetch accepts redirect
- redirect_valid  output  1  registered; redirect pending
- redirect_addr  output  ADDR_WIDTH  registered target
- id_stall  output  1  combinational; hold PC and IF/ID
- id_flush  output  1  combinational; invalidate IF/ID contents this cycle
- addr_misaligned  output  1  registered one-cycle pulse; taken target bit1 set

## Operation
- Decode on inst[6:0]: 1100011 BRANCH, 1101111 JAL, 1100111 JALR; all others ignored.
- Branch funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu. Funct3 010 and 011 are never taken.
- JAL target: pc + sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, modulo 2^ADDR_WIDTH.
- BRANCH and JALR need operands. JAL does not.
- States: IDLE, WAIT_OPND, REDIRECT. Reset: IDLE, redirect_valid=0, redirect_addr=0, addr_misaligned=0, id_stall=0, id_flush=0.
- IDLE, id_valid & BRANCH/JALR & !opnd_ready: id_stall=1; next state WAIT_OPND.
- IDLE, id_valid & control-flow instruction resolvable this cycle (the resolve cycle):
  - Taken, target[1]=0: redirect_addr <= target; next state REDIRECT.
  - Taken, target[1]=1: addr_misaligned pulses next cycle; no redirect; stay IDLE.
  - Not-taken: no action.
  - id_stall=0 in the resolve cycle.
- WAIT_OPND: id_stall=1 while !opnd_ready. When opnd_ready, resolve exactly as in IDLE (id_stall=0 that cycle) and take the same next state.
- REDIRECT:
  - redirect_valid=1 and id_flush=1 every cycle.
  - ID instructions are not evaluated.
  - redirect_valid & redirect_ready: next state IDLE; redirect_valid=0 next cycle.
  - redirect_addr is stable while valid.
- ex_flush (any state): next state IDLE, redirect_valid=0 next cycle. Combinational id_stall is forced to 0 in the same cycle. A redirect dropped by ex_flush is never delivered.
- ex_flush together with redirect_ready in REDIRECT: the handshake counts as accepted. The next state is IDLE either way.

## Timing
- Resolve at cycle T → redirect_valid at T+1 (1-cycle latency). Minimum 2 cycles from resolve to IDLE with redirect_ready tied high.
- Operand wait of N cycles adds N cycles of id_stall. Resolve occurs on the first opnd_ready cycle.
- Backpressure: redirect_valid and redirect_addr hold until accepted. There is no timeout.
- addr_misaligned is high exactly one cycle (T+1).
- A reset mid-REDIRECT or mid-WAIT_OPND returns to the reset values on the next edge. No pulse is emitted.

## Test plan
- Reset, then JAL at pc=0x1000 with imm=+0x20, redirect_ready=1 → redirect_valid at T+1 with addr 0x1020; id_flush=1 that cycle; IDLE at T+2.
- BEQ, opnd_ready low 2 cycles, then cmp_eq=1, bra_addr=0x2000 → id_stall=1 for 2 cycles, 0 on resolve; redirect 0x2000 one cycle later.
- BNE with cmp_eq=1 → not taken: no redirect, id_stall=0, state IDLE; funct3=010 → never taken.
- JALR with jalr_addr=0x3002 → addr_misaligned one-cycle pulse, redirect_valid stays 0.
- Taken BLTU, redirect_ready low 3 cycles → redirect_valid/addr held and id_flush=1 for 4 cycles; accepted on cycle 4.
- ex_flush during REDIRECT → redirect_valid=0 next cycle. Separately, rst during WAIT_OPND → all outputs at reset values next cycle.

Source files
------------

// File: rtl/stage_id_redirect_ctrl.sv
// ID-stage control-flow redirect controller: decodes BRANCH/JAL/JALR, stalls for
// operands, resolves the condition and hands a registered redirect to fetch.
module stage_id_redirect_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [INST_WIDTH-1:0] inst,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] bra_addr,
  input  logic [ADDR_WIDTH-1:0] jalr_addr,
  input  logic                  opnd_ready,
  input  logic                  cmp_eq,
  input  logic                  cmp_lt,
  input  logic                  cmp_ltu,
  input  logic                  ex_flush,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  id_stall,
  output logic                  id_flush,
  output logic                  addr_misaligned
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPND,
    REDIRECT
  } state_t;

  state_t                  state_reg, state_next;
  logic                    redirect_valid_reg, redirect_valid_next;
  logic [ADDR_WIDTH-1:0]   redirect_addr_reg, redirect_addr_next;
  logic                    misaligned_reg, misaligned_next;

  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic                    is_branch;
  logic                    is_jal;
  logic                    is_jalr;
  logic                    is_cf;
  logic                    needs_opnd;
  logic [20:0]             jal_imm;
  logic [ADDR_WIDTH-1:0]   jal_offset;
  logic [ADDR_WIDTH-1:0]   jal_target;
  logic                    branch_taken;
  logic                    cf_taken;
  logic [ADDR_WIDTH-1:0]   cf_target;

  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign is_branch  = (opcode == OP_BRANCH);
  assign is_jal     = (opcode == OP_JAL);
  assign is_jalr    = (opcode == OP_JALR);
  assign is_cf      = is_branch | is_jal | is_jalr;
  assign needs_opnd = is_branch | is_jalr;

  // J-type immediate, sign-extended to the full address width; wraps modulo 2^ADDR_WIDTH
  assign jal_imm    = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign jal_offset = {{(ADDR_WIDTH-21){jal_imm[20]}}, jal_imm};
  assign jal_target = pc + jal_offset;

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = cmp_eq;
      3'b001:  branch_taken = ~cmp_eq;
      3'b100:  branch_taken = cmp_lt;
      3'b101:  branch_taken = ~cmp_lt;
      3'b110:  branch_taken = cmp_ltu;
      3'b111:  branch_taken = ~cmp_ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    cf_taken  = 1'b0;
    cf_target = bra_addr;
    if (is_jal) begin
      cf_taken  = 1'b1;
      cf_target = jal_target;
    end else if (is_jalr) begin
      cf_taken  = 1'b1;
      cf_target = jalr_addr;
    end else if (is_branch) begin
      cf_taken  = branch_taken;
      cf_target = bra_addr;
    end
  end

  always_comb begin
    state_next          = state_reg;
    redirect_valid_next = redirect_valid_reg;
    redirect_addr_next  = redirect_addr_reg;
    misaligned_next     = 1'b0;
    id_stall            = 1'b0;
    id_flush            = 1'b0;

    case (state_reg)
      IDLE, WAIT_OPND: begin
        state_next = IDLE;
        if (id_valid && is_cf) begin
          if (needs_opnd && !opnd_ready) begin
            id_stall   = 1'b1;
            state_next = WAIT_OPND;
          end else if (cf_taken) begin
            // A target with bit1 set is reported instead of redirected
            if (cf_target[1]) begin
              misaligned_next = 1'b1;
            end else begin
              redirect_addr_next  = cf_target;
              redirect_valid_next = 1'b1;
              state_next          = REDIRECT;
            end
          end
        end
      end
      REDIRECT: begin
        id_flush = 1'b1;
        if (redirect_ready) begin
          redirect_valid_next = 1'b0;
          state_next          = IDLE;
        end
      end
      default: begin
        state_next          = IDLE;
        redirect_valid_next = 1'b0;
      end
    endcase

    // A later-stage flush overrides everything, including a pending redirect
    if (ex_flush) begin
      state_next          = IDLE;
      redirect_valid_next = 1'b0;
      redirect_addr_next  = redirect_addr_reg;
      misaligned_next     = 1'b0;
      id_stall            = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      redirect_valid_reg <= 1'b0;
      redirect_addr_reg  <= '0;
      misaligned_reg     <= 1'b0;
    end else begin
      state_reg          <= state_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_addr_reg  <= redirect_addr_next;
      misaligned_reg     <= misaligned_next;
    end
  end

  assign redirect_valid  = redirect_valid_reg;
  assign redirect_addr   = redirect_addr_reg;
  assign addr_misaligned = misaligned_reg;

endmodule
